// File: rtl/tap_pkg.sv
// Shared types for the TAP loader -> main-RAM write path.
//   tap_wr_state_t : RAM write handshake phases (IDLE, REQ, GAP).
//   tap_wr_entry_t : one queued byte write {addr[15:0], data[7:0]}.
//   TAP_WR_DEPTH   : default write-buffer depth.
package tap_pkg;

    localparam int TAP_WR_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } tap_wr_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } tap_wr_entry_t;

endpackage

// File: rtl/tap_wr_fifo.sv
// Small synchronous FIFO of tap_wr_entry_t used by tap_ram_writer.
// Ports:
//   clk_i, srst_i     : clock, synchronous active-high reset
//   push_i, din_i     : write din_i at the tail (ignored while full)
//   pop_i             : drop the head entry (ignored while empty)
//   clear_i           : empty the FIFO; overrides push and pop
//   head_o            : entry at the head (valid while !empty_o)
//   full_o, empty_o   : registered occupancy flags
//   count_o           : occupancy, 0..DEPTH
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.
module tap_wr_fifo
    import tap_pkg::*;
#(
    parameter int DEPTH = TAP_WR_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic                   push_i,
    input  tap_wr_entry_t          din_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output tap_wr_entry_t          head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    tap_wr_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the pre-edge registers, so a push into a full
    // FIFO is refused even when a pop happens on the same edge.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == (PW+1)'(DEPTH));
            empty_q <= (count_d == '0);
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Head is read straight from the array so IDLE can latch it on the
    // first edge after the entry lands.
    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/tap_ram_writer.sv
// Write buffer between the TAP loader and the main-RAM arbiter.
// Loader byte writes are queued in tap_wr_fifo and drained one at a time
// with a req/ack handshake, each write followed by one idle GAP cycle.
// Ports:
//   clk_sys, reset          : clock, synchronous active-high reset
//   in_addr, in_data, in_wr : loader write strobe with address/data
//   in_wait                 : FIFO full, loader must hold off
//   flush                   : discard queued writes (in-flight write completes)
//   ram_addr, ram_dout      : head entry presented to the arbiter
//   ram_req, ram_ack        : write request / one-cycle acceptance
//   idle                    : nothing queued and no request outstanding
//   overflow                : sticky, a write arrived while full
//   wr_count                : bytes acknowledged by RAM, wraps
module tap_ram_writer
    import tap_pkg::*;
#(
    parameter int DEPTH = TAP_WR_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [15:0]      in_addr,
    input  logic [7:0]       in_data,
    input  logic             in_wr,
    output logic             in_wait,
    input  logic             flush,
    output logic [15:0]      ram_addr,
    output logic [7:0]       ram_dout,
    output logic             ram_req,
    input  logic             ram_ack,
    output logic             idle,
    output logic             overflow,
    output logic [CNT_W-1:0] wr_count
);

    tap_wr_state_t           state_q;
    logic [15:0]             ram_addr_q;
    logic [7:0]              ram_dout_q;
    logic                    ram_req_q;
    logic                    overflow_q;
    logic [CNT_W-1:0]        wr_count_q;

    tap_wr_entry_t           fifo_din;
    tap_wr_entry_t           fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_clear;

    assign fifo_din   = '{addr: in_addr, data: in_data};
    // Loader writes are ignored while flushing.
    assign fifo_push  = in_wr && !flush;
    assign fifo_pop   = (state_q == REQ) && ram_ack;
    // An outstanding request is never aborted: in REQ the flush waits for
    // the ack and then empties the remainder on the same edge as the pop.
    assign fifo_clear = flush && ((state_q != REQ) || ram_ack);

    tap_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_sys),
        .srst_i  (reset),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .clear_i (fifo_clear),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_req_q  <= 1'b0;
            overflow_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            if (in_wr && !flush && fifo_full) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !flush) begin
                        ram_addr_q <= fifo_head.addr;
                        ram_dout_q <= fifo_head.data;
                        ram_req_q  <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (ram_ack) begin
                        ram_req_q  <= 1'b0;
                        wr_count_q <= wr_count_q + CNT_W'(1);
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    ram_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign in_wait  = fifo_full;
    assign idle     = (fifo_count == '0) && (state_q == IDLE);
    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    assign ram_req  = ram_req_q;
    assign overflow = overflow_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_tap_ram_writer.sv
module tb_tap_ram_writer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic [15:0]      in_addr;
    logic [7:0]       in_data;
    logic             in_wr;
    logic             flush;
    logic             ram_ack;
    logic             in_wait;
    logic [15:0]      ram_addr;
    logic [7:0]       ram_dout;
    logic             ram_req;
    logic             idle;
    logic             overflow;
    logic [CNT_W-1:0] wr_count;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    tap_ram_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .in_wr    (in_wr),
        .in_wait  (in_wait),
        .flush    (flush),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .ram_req  (ram_req),
        .ram_ack  (ram_ack),
        .idle     (idle),
        .overflow (overflow),
        .wr_count (wr_count)
    );

    // Reference model: queue of accepted writes, the write currently
    // offered to RAM, handshake phase (0 waiting, 1 requesting, 2 gap).
    logic [23:0] m_q[$];
    logic [23:0] m_cur;
    int          m_phase;
    bit          m_ovf;
    int          m_commits;

    task automatic step();
        bit was_full;
        int nphase;
        @(posedge clk_sys);
        if (reset) begin
            m_q.delete();
            m_cur = '0;
            m_phase = 0;
            m_ovf = 0;
            m_commits = 0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            nphase = m_phase;
            if (m_phase == 0 && m_q.size() != 0 && !flush) begin
                nphase = 1;
                m_cur = m_q[0];
            end else if (m_phase == 1 && ram_ack) begin
                nphase = 2;
            end else if (m_phase == 2) begin
                nphase = 0;
            end
            if (m_phase == 1 && ram_ack) begin
                void'(m_q.pop_front());
                m_commits++;
            end
            if (flush && (m_phase != 1 || ram_ack)) m_q.delete();
            else if (in_wr && !flush && !was_full) m_q.push_back({in_addr, in_data});
            if (in_wr && !flush && was_full) m_ovf = 1;
            m_phase = nphase;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; in_wr = 0; flush = 0; ram_ack = 0; in_addr = 0; in_data = 0;
        step(); step();
        checks++;
        if ({ram_req, ram_addr, ram_dout, in_wait, idle, overflow, wr_count} !== {1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_values: got req=%b addr=%h dout=%h wait=%b idle=%b ovf=%b cnt=%0d, want 0 0000 00 0 1 0 0",
                     ram_req, ram_addr, ram_dout, in_wait, idle, overflow, wr_count);
        end
        reset = 0;
        step();
        $display("reset: outputs at reset values checked");
    endtask

    task automatic test_single();
        logic [CNT_W-1:0] exp_cnt;
        exp_cnt = CNT_W'(m_commits + 1);
        in_wr = 1; in_addr = 16'hBB80; in_data = 8'h41;
        step();
        in_wr = 0;
        checks++;
        if (ram_req !== 1'b0 || idle !== 1'b0) begin
            errors++; $display("FAIL single_queued: got req=%b idle=%b, want req=0 idle=0", ram_req, idle);
        end
        step();
        checks++;
        if (ram_req !== 1'b1 || ram_addr !== 16'hBB80 || ram_dout !== 8'h41) begin
            errors++; $display("FAIL single_req: got req=%b addr=%h dout=%h, want 1 bb80 41", ram_req, ram_addr, ram_dout);
        end
        ram_ack = 1; step(); ram_ack = 0;
        checks++;
        if (ram_req !== 1'b0 || wr_count !== exp_cnt || idle !== 1'b0) begin
            errors++; $display("FAIL single_ack: got req=%b cnt=%0d idle=%b, want 0 %0d 0", ram_req, wr_count, idle, exp_cnt);
        end
        step();
        checks++;
        if (idle !== 1'b1 || ram_req !== 1'b0) begin
            errors++; $display("FAIL single_idle: got idle=%b req=%b, want 1 0", idle, ram_req);
        end
        $display("single: write bb80/41 committed, wr_count=%0d", wr_count);
    endtask

    task automatic test_fill();
        logic [CNT_W-1:0] exp_cnt;
        exp_cnt = CNT_W'(m_commits + 4);
        for (int k = 0; k < 4; k++) begin
            in_wr = 1; in_addr = 16'h0501 + 16'(k); in_data = 8'hA0 + 8'(k);
            step();
        end
        in_wr = 0;
        checks++;
        if (in_wait !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL fill_wait: got wait=%b ovf=%b, want 1 0", in_wait, overflow);
        end
        in_wr = 1; in_addr = 16'h0505; in_data = 8'hA4;
        step();
        in_wr = 0;
        checks++;
        if (overflow !== 1'b1 || in_wait !== 1'b1) begin
            errors++; $display("FAIL fill_overflow: got ovf=%b wait=%b, want 1 1", overflow, in_wait);
        end
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 20 && ram_req !== 1'b1; t++) step();
            checks++;
            if (ram_req !== 1'b1 || ram_addr !== 16'h0501 + 16'(k) || ram_dout !== 8'hA0 + 8'(k)) begin
                errors++; $display("FAIL fill_drain%0d: got req=%b addr=%h dout=%h, want 1 %h %h",
                                   k, ram_req, ram_addr, ram_dout, 16'h0501 + 16'(k), 8'hA0 + 8'(k));
            end
            $display("fill: drained addr=%h dout=%h", ram_addr, ram_dout);
            ram_ack = 1; step(); ram_ack = 0;
        end
        for (int t = 0; t < 4; t++) step();
        checks++;
        if (wr_count !== exp_cnt || idle !== 1'b1 || ram_req !== 1'b0 || in_wait !== 1'b0) begin
            errors++; $display("FAIL fill_done: got cnt=%0d idle=%b req=%b wait=%b, want %0d 1 0 0",
                               wr_count, idle, ram_req, in_wait, exp_cnt);
        end
    endtask

    task automatic test_slow_arbiter();
        logic [15:0]      a0, a1;
        logic [7:0]       d0, d1;
        logic [CNT_W-1:0] exp_cnt;
        a0 = 16'($urandom); d0 = 8'($urandom); a1 = 16'($urandom); d1 = 8'($urandom);
        exp_cnt = CNT_W'(m_commits);
        in_wr = 1; in_addr = a0; in_data = d0; step();
        in_addr = a1; in_data = d1; step();
        in_wr = 0;
        for (int t = 0; t < 20 && ram_req !== 1'b1; t++) step();
        for (int t = 0; t < 10; t++) begin
            checks++;
            if (ram_req !== 1'b1 || ram_addr !== a0 || ram_dout !== d0 || wr_count !== exp_cnt) begin
                errors++; $display("FAIL slow_hold%0d: got req=%b addr=%h dout=%h cnt=%0d, want 1 %h %h %0d",
                                   t, ram_req, ram_addr, ram_dout, wr_count, a0, d0, exp_cnt);
            end
            step();
        end
        ram_ack = 1; step(); ram_ack = 0;
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (ram_req !== 1'b0 || wr_count !== exp_cnt) begin
            errors++; $display("FAIL slow_ack: got req=%b cnt=%0d, want 0 %0d", ram_req, wr_count, exp_cnt);
        end
        for (int t = 0; t < 20 && ram_req !== 1'b1; t++) step();
        checks++;
        if (ram_req !== 1'b1 || ram_addr !== a1 || ram_dout !== d1) begin
            errors++; $display("FAIL slow_second: got req=%b addr=%h dout=%h, want 1 %h %h", ram_req, ram_addr, ram_dout, a1, d1);
        end
        ram_ack = 1; step(); ram_ack = 0;
        exp_cnt = exp_cnt + 1'b1;
        step(); step();
        ram_ack = 1; step(); ram_ack = 0;
        step();
        checks++;
        if (wr_count !== exp_cnt || ram_req !== 1'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL slow_stray_ack: got cnt=%0d req=%b idle=%b, want %0d 0 1", wr_count, ram_req, idle, exp_cnt);
        end
        $display("slow: two writes over a 10-cycle ack delay, wr_count=%0d", wr_count);
    endtask

    task automatic test_flush_req();
        logic [CNT_W-1:0] exp_cnt;
        exp_cnt = CNT_W'(m_commits + 1);
        for (int k = 0; k < 3; k++) begin
            in_wr = 1; in_addr = 16'h0601 + 16'(k); in_data = 8'h10 + 8'(k);
            step();
        end
        in_wr = 0;
        for (int t = 0; t < 20 && ram_req !== 1'b1; t++) step();
        flush = 1;
        step(); step();
        checks++;
        if (ram_req !== 1'b1 || ram_addr !== 16'h0601 || ram_dout !== 8'h10) begin
            errors++; $display("FAIL flush_hold: got req=%b addr=%h dout=%h, want 1 0601 10", ram_req, ram_addr, ram_dout);
        end
        ram_ack = 1; step(); ram_ack = 0; flush = 0;
        checks++;
        if (ram_req !== 1'b0 || wr_count !== exp_cnt || idle !== 1'b0) begin
            errors++; $display("FAIL flush_ack: got req=%b cnt=%0d idle=%b, want 0 %0d 0", ram_req, wr_count, idle, exp_cnt);
        end
        step();
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL flush_idle: got idle=%b, want 1", idle);
        end
        step(); step(); step();
        checks++;
        if (ram_req !== 1'b0 || idle !== 1'b1 || wr_count !== exp_cnt) begin
            errors++; $display("FAIL flush_discard: got req=%b idle=%b cnt=%0d, want 0 1 %0d", ram_req, idle, wr_count, exp_cnt);
        end
        $display("flush: head committed, remainder discarded, wr_count=%0d", wr_count);
    endtask

    task automatic test_random();
        logic [31:0] exp_v, got_v;
        for (int c = 0; c < 450; c++) begin
            if (c < 400) begin
                in_wr   = ($urandom_range(0, 1) == 1);
                in_addr = 16'($urandom);
                in_data = 8'($urandom);
                flush   = ($urandom_range(0, 15) == 0);
                ram_ack = ($urandom_range(0, 2) != 0);
            end else begin
                in_wr = 0; flush = 0; ram_ack = 1;
            end
            step();
            exp_v = {(m_phase == 1), m_cur, (m_q.size() == DEPTH), (m_q.size() == 0 && m_phase == 0), m_ovf, 4'(m_commits)};
            got_v = {ram_req, ram_addr, ram_dout, in_wait, idle, overflow, wr_count};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL random_cycle%0d: got %h, want %h (req,addr,dout,wait,idle,ovf,cnt)", c, got_v, exp_v);
            end
        end
        ram_ack = 0;
        step();
        $display("random: 450 cycles compared, commits=%0d", m_commits);
    endtask

    task automatic test_reset_mid();
        in_wr = 1; in_addr = 16'h1234; in_data = 8'h77; step();
        in_wr = 0;
        for (int t = 0; t < 20 && ram_req !== 1'b1; t++) step();
        checks++;
        if (ram_req !== 1'b1) begin
            errors++; $display("FAIL reset_mid_req: got req=%b, want 1", ram_req);
        end
        reset = 1; step(); reset = 0;
        checks++;
        if ({ram_req, ram_addr, ram_dout, in_wait, idle, overflow, wr_count} !== {1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_mid_values: got req=%b addr=%h dout=%h wait=%b idle=%b ovf=%b cnt=%0d, want 0 0000 00 0 1 0 0",
                     ram_req, ram_addr, ram_dout, in_wait, idle, overflow, wr_count);
        end
        in_wr = 1; in_addr = 16'h9800; in_data = 8'h55; step();
        in_wr = 0;
        for (int t = 0; t < 20 && ram_req !== 1'b1; t++) step();
        checks++;
        if (ram_req !== 1'b1 || ram_addr !== 16'h9800 || ram_dout !== 8'h55) begin
            errors++; $display("FAIL reset_mid_after: got req=%b addr=%h dout=%h, want 1 9800 55", ram_req, ram_addr, ram_dout);
        end
        ram_ack = 1; step(); ram_ack = 0; step();
        checks++;
        if (wr_count !== 4'd1 || idle !== 1'b1) begin
            errors++; $display("FAIL reset_mid_commit: got cnt=%0d idle=%b, want 1 1", wr_count, idle);
        end
        $display("reset_mid: request withdrawn, 9800/55 committed after reset");
    endtask

    task automatic test_wrap();
        reset = 1; step(); reset = 0;
        for (int k = 0; k < 17; k++) begin
            in_wr = 1; in_addr = 16'(k); in_data = 8'(k); step();
            in_wr = 0;
            for (int t = 0; t < 20 && ram_req !== 1'b1; t++) step();
            ram_ack = 1; step(); ram_ack = 0;
            step();
            if (k == 15) begin
                checks++;
                if (wr_count !== 4'd0) begin
                    errors++; $display("FAIL wrap_16: got cnt=%0d, want 0", wr_count);
                end
            end
        end
        checks++;
        if (wr_count !== 4'd1) begin
            errors++; $display("FAIL wrap_17: got cnt=%0d, want 1", wr_count);
        end
        $display("wrap: 17 commits, wr_count=%0d", wr_count);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_slow_arbiter();
        test_flush_req();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tap_ram_writer.md
# tap_ram_writer

Write buffer between the TAP loader and the Oric main-RAM port. Accepts single-byte write pulses (address plus data) from the loader, queues them in a small FIFO, and drains them to the RAM arbiter with a req/ack handshake. Backpressure to the loader is a single wait line, so the loader never has to track RAM timing. It also reports an idle indication, a sticky overflow flag and a count of bytes committed to RAM.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 16: width of the committed-byte counter.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_addr  in  16  loader write address.
- in_data  in  8  loader write data.
- in_wr  in  1  one-cycle write strobe; addr/data valid in the same cycle.
- in_wait  out  1  high = FIFO full; loader must hold off in_wr.
- flush  in  1  level; discard all queued writes.
- ram_addr  out  16  address of the head entry.
- ram_dout  out  8  data of the head entry.
- ram_req  out  1  write request to the RAM arbiter.
- ram_ack  in  1  one-cycle acceptance from the arbiter.
- idle  out  1  FIFO empty and no request outstanding.
- overflow  out  1  sticky; an in_wr arrived while full.
- wr_count  out  CNT_W  bytes acknowledged by RAM since reset; wraps.

## Operation
- Push: if in_wr && !full, the {in_addr, in_data} entry is written at the tail. If in_wr && full, the byte is dropped and overflow is set. overflow clears only on reset.
- FSM states:
  - IDLE: ram_req=0. If the FIFO is non-empty and flush=0, latch the head into ram_addr/ram_dout and go to REQ.
  - REQ: ram_req=1, with addr/data stable. On ram_ack: pop the head, increment wr_count, and go to GAP.
  - GAP: ram_req=0 for exactly one cycle, then go to IDLE.
- ram_ack outside REQ is ignored. It does not pop and does not count.
- flush:
  - In IDLE or GAP, the FIFO is emptied at the clock edge.
  - In REQ, the outstanding request is held until ram_ack. Memory writes are never aborted. The acknowledged byte is counted, and the remaining entries are emptied in the same edge as the pop.
  - While flush=1, in_wr is ignored and overflow is not set.
- Simultaneous push and pop while full: the pop takes effect and the push is refused. Full is evaluated on the pre-edge count; there is no pass-through.
- Simultaneous push and pop otherwise: both take effect and count is unchanged.
- Counts and pointers wrap modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits wide.
- wr_count wraps from 2^CNT_W-1 to 0.

## Timing
Reset values:
- ram_req=0, ram_addr=0, ram_dout=0.
- in_wait=0, idle=1, overflow=0, wr_count=0.
- FSM in IDLE, FIFO empty.

Registered outputs and flags:
- All outputs are registered.
- in_wait equals (count==DEPTH) and updates the cycle after the push or pop that changes it.
- idle equals (count==0 && state==IDLE).

Latency:
- An in_wr at edge N into an empty, idle block gives ram_req=1 after edge N+1.
- The ram_ack cycle is followed by one GAP cycle.
- Sustained throughput is one byte per 3 cycles when the arbiter acks immediately.

Handshake:
- ram_req stays high and addr/data stay constant until ram_ack is sampled high.
- ram_req deasserts on the edge that samples ram_ack.

Reset mid-operation:
- All state returns to reset values at the next edge.
- ram_req drops even if unacknowledged. The arbiter must tolerate a withdrawn request on reset.

## Structure
- Shared package tap_pkg: the FSM enum tap_wr_state_t {IDLE, REQ, GAP}, the DEPTH default constant, and the typedef tap_wr_entry_t (packed struct: addr[15:0], data[7:0]).
- One sub-module, tap_wr_fifo: synchronous FIFO of tap_wr_entry_t.
  - Inputs: push, pop, clear.
  - Outputs: head, full, empty, count.
  - It is used only by this block and is parameterised by DEPTH.
- The FSM, overflow flag and wr_count live in tap_ram_writer.

## Test plan
- Single write: in_wr with addr 16'hBB80, data 8'h41, and ram_ack one cycle after ram_req rises.
  - ram_req rises 2 cycles after in_wr with ram_addr BB80 and ram_dout 41.
  - wr_count=1 and idle=1 three cycles later.
- Fill: 4 back-to-back writes to 0501..0504 with ram_ack held low.
  - in_wait=1 after the 4th write.
  - A 5th write to 0505 sets overflow.
  - Releasing acks drains exactly 0501..0504 in order, and wr_count=4.
- Slow arbiter: ram_ack delayed 10 cycles.
  - ram_req, ram_addr and ram_dout are stable for all 10 cycles.
  - Exactly one pop per ack.
  - A stray ram_ack in IDLE has no effect.
- Flush during REQ: 3 entries queued, flush asserted while REQ is waiting.
  - The head is written after ack and wr_count=1.
  - The other 2 entries are discarded, and idle=1 two cycles later.
- Reset mid-request: reset asserted while ram_req=1.
  - After the next edge, every output equals its reset value.
  - A subsequent write to 9800/55 is handled normally.
- wr_count wrap: with CNT_W=4, commit 17 bytes; wr_count reads 1.
